// File: rtl/fp_addsub_if.sv
`default_nettype none
// ============================================================================
// fp_addsub_if : operand/result handshake bundle for fp_addsub_seq
// Revision 1.0
// ============================================================================
interface fp_addsub_if #(
   parameter int EXP_W = 4,
   parameter int MAN_W = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic [EXP_W+MAN_W:0]     in_a;
   logic [EXP_W+MAN_W:0]     in_b;
   logic                     op;
   logic                     out_valid;
   logic                     out_ready;
   logic [EXP_W+MAN_W:0]     out_result;
   logic                     ovf;
   logic                     unf;

   modport master (
      output in_valid, in_a, in_b, op, out_ready,
      input  in_ready, out_valid, out_result, ovf, unf
   );

   modport slave (
      input  in_valid, in_a, in_b, op, out_ready,
      output in_ready, out_valid, out_result, ovf, unf
   );
endinterface
`default_nettype wire

// File: rtl/fp_addsub_seq.sv
`default_nettype none
// ============================================================================
// fp_addsub_seq : multi-cycle add/subtract for {s,e,m} = (-1)^s * 0.m * 2^e
// Revision 1.0
// ============================================================================
module fp_addsub_seq #(
   parameter int EXP_W = 4,
   parameter int MAN_W = 8
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   fp_addsub_if.slave  bus
);
   localparam int W = 1 + EXP_W + MAN_W;

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
   state_t state, state_nx;

   logic             sl, ss, res_s, ovf_r, unf_r;
   logic [EXP_W-1:0] el, d, res_e;
   logic [MAN_W-1:0] ml, ms, res_m;

   // Operand ordering at capture; B sign flipped for subtraction.
   logic             b_s, swap, far;
   logic             cap_sl, cap_ss;
   logic [EXP_W-1:0] cap_el, cap_es, cap_d;
   logic [MAN_W-1:0] cap_ml, cap_ms;

   assign b_s    = bus.in_b[W-1] ^ bus.op;
   assign swap   = bus.in_b[W-2:0] > bus.in_a[W-2:0];
   assign cap_sl = swap ? b_s : bus.in_a[W-1];
   assign cap_ss = swap ? bus.in_a[W-1] : b_s;
   assign cap_el = swap ? bus.in_b[W-2:MAN_W] : bus.in_a[W-2:MAN_W];
   assign cap_es = swap ? bus.in_a[W-2:MAN_W] : bus.in_b[W-2:MAN_W];
   assign cap_ml = swap ? bus.in_b[MAN_W-1:0] : bus.in_a[MAN_W-1:0];
   assign cap_ms = swap ? bus.in_a[MAN_W-1:0] : bus.in_b[MAN_W-1:0];
   assign cap_d  = cap_el - cap_es;
   assign far    = {{(32-EXP_W){1'b0}}, cap_d} >= 32'(MAN_W);

   logic [MAN_W:0]   sum;
   logic [MAN_W-1:0] diff;
   logic             norm_exit;

   assign sum       = {1'b0, ml} + {1'b0, ms};
   assign diff      = ml - ms;
   assign norm_exit = res_m[MAN_W-1] || (res_m == '0) || (res_e == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.in_valid)     state_nx = ALIGN;
         ALIGN:   if (d == '0)          state_nx = ADD;
         ADD:                           state_nx = NORM;
         NORM:    if (norm_exit)        state_nx = DONE;
         DONE:    if (bus.out_ready)    state_nx = IDLE;
         default:                       state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sl <= 1'b0; ss <= 1'b0; el <= '0; d <= '0; ml <= '0; ms <= '0;
         res_s <= 1'b0; res_e <= '0; res_m <= '0; ovf_r <= 1'b0; unf_r <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               sl    <= cap_sl;
               ss    <= cap_ss;
               el    <= cap_el;
               ml    <= cap_ml;
               ms    <= far ? '0 : cap_ms;
               d     <= far ? '0 : cap_d;
               ovf_r <= 1'b0;
               unf_r <= 1'b0;
            end
            ALIGN: if (d != '0) begin
               ms <= ms >> 1;
               d  <= d - 1'b1;
            end
            ADD: begin
               if (sl == ss) begin
                  res_s <= sl;
                  if (sum[MAN_W]) begin
                     if (el == '1) begin
                        res_e <= '1;
                        res_m <= '1;
                        ovf_r <= 1'b1;
                     end else begin
                        res_e <= el + 1'b1;
                        res_m <= sum[MAN_W:1];
                     end
                  end else begin
                     res_e <= el;
                     res_m <= sum[MAN_W-1:0];
                  end
               end else if (diff == '0) begin
                  res_s <= 1'b0;
                  res_e <= '0;
                  res_m <= '0;
               end else begin
                  res_s <= sl;
                  res_e <= el;
                  res_m <= diff;
               end
            end
            NORM: begin
               if (norm_exit) begin
                  unf_r <= (res_e == '0) && (res_m != '0) && !res_m[MAN_W-1];
               end else begin
                  res_m <= res_m << 1;
                  res_e <= res_e - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready   = (state == IDLE);
   assign bus.out_valid  = (state == DONE);
   assign bus.out_result = {res_s, res_e, res_m};
   assign bus.ovf        = ovf_r;
   assign bus.unf        = unf_r;
endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_seq.sv
`default_nettype none
// tb_fp_addsub_seq : directed and random add/subtract transactions checked
// against a value-level model of the float format.
module tb_fp_addsub_seq;
   localparam int EXP_W = 4;
   localparam int MAN_W = 8;
   localparam int W     = 1 + EXP_W + MAN_W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fp_addsub_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

   fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [W-1:0] res;
      logic         ovf;
      logic         unf;
      int           align;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Value-level reference: order, align by truncating divide, add, renormalise.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
      exp_t r;
      int sa, sb, ea, eb, ma, mb, sl, ss, el, es, ml, ms, d, s, e, m, sh;
      int half = 1 << (MAN_W - 1);
      int full = 1 << MAN_W;
      int emax = (1 << EXP_W) - 1;
      sa = int'(a[W-1]);           sb = int'(b[W-1] ^ o);
      ea = int'(a[W-2:MAN_W]);     eb = int'(b[W-2:MAN_W]);
      ma = int'(a[MAN_W-1:0]);     mb = int'(b[MAN_W-1:0]);
      if (eb * full + mb > ea * full + ma) begin
         sl = sb; el = eb; ml = mb; ss = sa; es = ea; ms = ma;
      end else begin
         sl = sa; el = ea; ml = ma; ss = sb; es = eb; ms = mb;
      end
      d = el - es;
      if (d >= MAN_W) begin ms = 0; r.align = 1; end
      else begin ms = ms / (1 << d); r.align = d + 1; end
      r.ovf = 1'b0;
      if (sl == ss) begin
         s = sl; e = el; m = ml + ms;
         if (m >= full) begin
            if (el == emax) begin m = full - 1; r.ovf = 1'b1; end
            else begin m = m / 2; e = el + 1; end
         end
      end else begin
         m = ml - ms;
         if (m == 0) begin s = 0; e = 0; end
         else begin s = sl; e = el; end
      end
      sh = 0;
      while (m != 0 && m < half && e != 0) begin m = m * 2; e = e - 1; sh++; end
      r.unf = (e == 0 && m != 0 && m < half);
      r.res = {1'(s), EXP_W'(e), MAN_W'(m)};
      // Samples counted from the accept edge up to the first out_valid sample.
      r.cyc = r.align + 1 + (sh + 1) + 1;
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            chk("result", 32'(bus.out_result), 32'(exp_q[0].res));
            chk("ovf", 32'(bus.ovf), 32'(exp_q[0].ovf));
            chk("unf", 32'(bus.unf), 32'(exp_q[0].unf));
            chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
         end
      end
   end

   always @(posedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready && exp_q.size() > 0)
         void'(exp_q.pop_front());
   end

   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                      input int hold, input bit pulse, input bit rst_mid);
      exp_t e;
      int   n;
      e = model(a, b, o);
      @(negedge clk);
      n = 0;
      while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
      if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
      bus.in_a = a; bus.in_b = b; bus.op = o; bus.in_valid = 1'b1;
      @(posedge clk);
      exp_q.push_back(e);
      #1 bus.in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (pulse && n == 2) begin
            bus.in_a = 13'b0_1111_10000000; bus.in_b = 13'b0_1111_10000000;
            bus.op = 1'b0; bus.in_valid = 1'b1;
         end
         if (pulse && n == 4) bus.in_valid = 1'b0;
         if (rst_mid && n == e.align + 3) begin
            rst_n = 1'b0;
            #1;
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
            chk("rst_result", 32'(bus.out_result), 32'd0);
            chk("rst_flags", {30'd0, bus.ovf, bus.unf}, 32'd0);
            exp_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
      end while (!bus.out_valid && n < 200);
      chk("latency", 32'(n), 32'(e.cyc));
      repeat (hold) @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
      chk("in_ready_back", 32'(bus.in_ready), 32'd1);
   endtask

   function automatic logic [W-1:0] rnd_op();
      if ($urandom_range(0, 7) == 0) return '0;
      return {1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1, 7'($urandom_range(0, 127))};
   endfunction

   initial begin
      exp_t p;
      logic [W-1:0] a, b;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 1'b0;
      bus.in_a = '0; bus.in_b = '0;
      repeat (2) @(negedge clk);
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_result", 32'(bus.out_result), 32'd0);
      chk("reset_ovf", 32'(bus.ovf), 32'd0);
      chk("reset_unf", 32'(bus.unf), 32'd0);
      rst_n = 1'b1;

      // Hand-computed pins on the model itself.
      p = model(13'b0_0001_10000000, 13'b0_0001_10000000, 1'b0);
      chk("model_1p1", 32'(p.res), 32'(13'b0_0010_10000000));
      chk("model_1p1_cyc", 32'(p.cyc), 32'd4);
      p = model(13'b0_0111_10000000, 13'b0_0001_10000000, 1'b0);
      chk("model_64p1", 32'(p.res), 32'(13'b0_0111_10000010));
      chk("model_64p1_align", 32'(p.align), 32'd7);
      p = model(13'b0_0000_10000000, 13'b1_0001_11110000, 1'b0);
      chk("model_mixed", 32'(p.res), 32'(13'b1_0001_10110000));
      p = model(13'b0_1111_10000000, 13'b0_1111_10000000, 1'b0);
      chk("model_ovf", {19'd0, p.ovf, p.res}, {19'd0, 1'b1, 13'b0_1111_11111111});
      p = model(13'b0_0011_10000001, 13'b0_0011_10000000, 1'b1);
      chk("model_unf", {19'd0, p.unf, p.res}, {19'd0, 1'b1, 13'b0_0000_00001000});
      p = model(13'b0_0001_10000000, 13'b0_0001_10000000, 1'b1);
      chk("model_cancel", {19'd0, p.unf, p.res}, 32'd0);

      run(13'b0_0001_10000000, 13'b0_0001_10000000, 1'b0, 5, 1'b0, 1'b0);
      run(13'b0_0111_10000000, 13'b0_0001_10000000, 1'b0, 1, 1'b1, 1'b0);
      run(13'b0_0000_10000000, 13'b1_0001_11110000, 1'b0, 0, 1'b0, 1'b0);
      run(13'b0_1111_10000000, 13'b0_1111_10000000, 1'b0, 2, 1'b0, 1'b0);
      run(13'b0_0011_10000001, 13'b0_0011_10000000, 1'b1, 0, 1'b0, 1'b0);
      run(13'b0_0001_10000000, 13'b0_0001_10000000, 1'b1, 0, 1'b0, 1'b0);
      run(13'b0_0011_10000001, 13'b0_0011_10000000, 1'b1, 0, 1'b0, 1'b1);
      run(13'b0_0011_10000001, 13'b0_0011_10000000, 1'b1, 1, 1'b0, 1'b0);
      run(13'b0_1010_11000000, 13'b0_0010_11111111, 1'b0, 0, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         a = rnd_op();
         if ($urandom_range(0, 2) == 0) b = {~a[W-1], a[W-2:3], 3'($urandom_range(0, 7))};
         else                           b = rnd_op();
         run(a, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
